// File: rtl/axi_lite_regfile_slv.sv
// AXI4-Lite register-file responder: NumRegs byte-strobed registers with
// read-only masking and DECERR/SLVERR responses, independent B and R channels.
package axi_lite_regfile_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module axi_lite_regfile_slv #(
  parameter int unsigned                           NumRegs      = 32'd4,
  parameter int unsigned                           AxiAddrWidth = 32'd32,
  parameter int unsigned                           AxiDataWidth = 32'd32,
  parameter logic [NumRegs-1:0]                    ReadOnlyMask = '0,
  parameter logic [NumRegs-1:0][AxiDataWidth-1:0] RegRstVal    = '0,
  parameter type                                   req_t        = axi_lite_regfile_pkg::req_t,
  parameter type                                   resp_t       = axi_lite_regfile_pkg::resp_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  req_t                                   slv_req_i,
  output resp_t                                  slv_resp_o,
  input  logic [NumRegs-1:0][AxiDataWidth-1:0]  rd_only_i,
  output logic [NumRegs-1:0][AxiDataWidth-1:0]  reg_q_o,
  output logic [NumRegs-1:0]                     wr_pulse_o
);

  localparam int unsigned StrbW   = AxiDataWidth / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = AxiAddrWidth - AddrLsb;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [AxiDataWidth-1:0] strb_merge(
    input logic [AxiDataWidth-1:0] old_val,
    input logic [AxiDataWidth-1:0] new_val,
    input logic [StrbW-1:0]        strb
  );
    logic [AxiDataWidth-1:0] res;
    res = old_val;
    for (int b = 0; b < StrbW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [NumRegs-1:0][AxiDataWidth-1:0] regs_p1;
  logic [NumRegs-1:0]                   wr_pulse_p1;
  logic [0:0]                           wr_state_p1;
  logic [0:0]                           rd_state_p1;
  logic [1:0]                           b_resp_p1;
  logic [1:0]                           r_resp_p1;
  logic [AxiDataWidth-1:0]              r_data_p1;

  logic                    b_vld_p1, r_vld_p1;
  logic                    wr_hs, rd_rdy, rd_hs;
  logic [IdxW-1:0]         aw_idx, ar_idx;
  logic [NumRegs-1:0]      wr_sel;
  logic [1:0]              b_resp_d, r_resp_d;
  logic [AxiDataWidth-1:0] r_data_d;
  logic                    unused_bits;

  assign b_vld_p1 = (wr_state_p1 == ST_RESP);
  assign r_vld_p1 = (rd_state_p1 == ST_RESP);

  // Write only when both AW and W are present; a lone channel waits.
  assign wr_hs  = slv_req_i.aw_valid && slv_req_i.w_valid && (!b_vld_p1 || slv_req_i.b_ready);
  assign rd_rdy = !r_vld_p1 || slv_req_i.r_ready;
  assign rd_hs  = slv_req_i.ar_valid && rd_rdy;

  assign aw_idx = slv_req_i.aw.addr[AxiAddrWidth-1:AddrLsb];
  assign ar_idx = slv_req_i.ar.addr[AxiAddrWidth-1:AddrLsb];

  assign unused_bits = ^{slv_req_i.aw.prot, slv_req_i.ar.prot,
                         slv_req_i.aw.addr[AddrLsb-1:0], slv_req_i.ar.addr[AddrLsb-1:0]};

  always_comb begin
    for (int k = 0; k < NumRegs; k++) begin
      reg_q_o[k] = ReadOnlyMask[k] ? rd_only_i[k] : regs_p1[k];
    end
  end

  // Indices beyond NumRegs match no entry and fall through to DECERR.
  always_comb begin
    wr_sel   = '0;
    b_resp_d = RESP_DECERR;
    r_data_d = '0;
    r_resp_d = RESP_DECERR;
    for (int k = 0; k < NumRegs; k++) begin
      if (aw_idx == IdxW'(k)) begin
        if (ReadOnlyMask[k]) begin
          b_resp_d = RESP_SLVERR;
        end else begin
          b_resp_d  = RESP_OKAY;
          wr_sel[k] = wr_hs;
        end
      end
      if (ar_idx == IdxW'(k)) begin
        r_data_d = reg_q_o[k];
        r_resp_d = RESP_OKAY;
      end
    end
  end

  // Stage p1: write commit and B response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_p1 <= ST_IDLE;
      b_resp_p1   <= '0;
      regs_p1     <= RegRstVal;
      wr_pulse_p1 <= '0;
    end else begin
      wr_pulse_p1 <= wr_sel;
      for (int k = 0; k < NumRegs; k++) begin
        if (wr_sel[k]) regs_p1[k] <= strb_merge(regs_p1[k], slv_req_i.w.data, slv_req_i.w.strb);
      end
      if (wr_hs) begin
        wr_state_p1 <= ST_RESP;
        b_resp_p1   <= b_resp_d;
      end else if (slv_req_i.b_ready) begin
        wr_state_p1 <= ST_IDLE;
      end
    end
  end

  // Stage p1: read capture and R response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_p1 <= ST_IDLE;
      r_resp_p1   <= '0;
      r_data_p1   <= '0;
    end else begin
      if (rd_hs) begin
        rd_state_p1 <= ST_RESP;
        r_resp_p1   <= r_resp_d;
        r_data_p1   <= r_data_d;
      end else if (slv_req_i.r_ready) begin
        rd_state_p1 <= ST_IDLE;
      end
    end
  end

  assign wr_pulse_o = wr_pulse_p1;

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = wr_hs;
    slv_resp_o.w_ready  = wr_hs;
    slv_resp_o.b.resp   = b_resp_p1;
    slv_resp_o.b_valid  = b_vld_p1;
    slv_resp_o.ar_ready = rd_rdy;
    slv_resp_o.r.data   = r_data_p1;
    slv_resp_o.r.resp   = r_resp_p1;
    slv_resp_o.r_valid  = r_vld_p1;
  end

endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
// Directed bench for axi_lite_regfile_slv: vector table plus stall,
// same-cycle read/write and mid-transaction reset sequences.
module tb_axi_lite_regfile_slv;
  import axi_lite_regfile_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  req_t             req;
  resp_t            resp;
  logic [3:0][31:0] rd_only;
  logic [3:0][31:0] reg_q;
  logic [3:0]       wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_regfile_slv #(
    .NumRegs     (4),
    .AxiAddrWidth(32),
    .AxiDataWidth(32),
    .ReadOnlyMask(4'b1000),
    .RegRstVal   ('0),
    .req_t       (req_t),
    .resp_t      (resp_t)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .slv_req_i (req),
    .slv_resp_o(resp),
    .rd_only_i (rd_only),
    .reg_q_o   (reg_q),
    .wr_pulse_o(wr_pulse)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pulse;
    int          chk_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input vec_t v);
    @(negedge clk_i);
    req.aw.addr  = v.addr;
    req.aw_valid = 1'b1;
    req.w.data   = v.data;
    req.w.strb   = v.strb;
    req.w_valid  = 1'b1;
    req.b_ready  = 1'b1;
    #1;
    check("wr_ready", {resp.aw_ready, resp.w_ready}, 2'b11);
    @(negedge clk_i);
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    #1;
    check("b_valid", resp.b_valid, 1'b1);
    check("b_resp", resp.b.resp, v.exp_resp);
    check("wr_pulse", wr_pulse, v.exp_pulse);
    check("reg_after_wr", reg_q[v.chk_idx], v.exp_reg);
    @(negedge clk_i);
    #1;
    check("pulse_cleared", wr_pulse, 4'b0000);
    check("b_valid_cleared", resp.b_valid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    @(negedge clk_i);
    req.ar.addr  = addr;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    #1;
    check("ar_ready", resp.ar_ready, 1'b1);
    @(negedge clk_i);
    req.ar_valid = 1'b0;
    #1;
    check("r_valid", resp.r_valid, 1'b1);
    check("r_resp", resp.r.resp, exp_resp);
    check("r_data", resp.r.data, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr    data          strb     resp   rdata         pulse    idx reg
    vecs[0]  = '{1'b1, 32'h4,  32'hDEADBEEF, 4'hF,    2'b00, 32'h0,        4'b0010, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h4,  32'h000000AA, 4'b0001, 2'b00, 32'h0,        4'b0010, 1, 32'hDEADBEAA};
    vecs[2]  = '{1'b0, 32'h4,  32'h0,        4'h0,    2'b00, 32'hDEADBEAA, 4'b0000, 1, 32'hDEADBEAA};
    vecs[3]  = '{1'b1, 32'hC,  32'hFFFFFFFF, 4'hF,    2'b10, 32'h0,        4'b0000, 3, 32'h12345678};
    vecs[4]  = '{1'b0, 32'hC,  32'h0,        4'h0,    2'b00, 32'h12345678, 4'b0000, 3, 32'h12345678};
    vecs[5]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'hF,    2'b11, 32'h0,        4'b0000, 1, 32'hDEADBEAA};
    vecs[6]  = '{1'b0, 32'h10, 32'h0,        4'h0,    2'b11, 32'h0,        4'b0000, 1, 32'hDEADBEAA};
    vecs[7]  = '{1'b1, 32'h0,  32'hFFFFFFFF, 4'h0,    2'b00, 32'h0,        4'b0001, 0, 32'h00000000};
    vecs[8]  = '{1'b1, 32'h8,  32'h11223344, 4'b1100, 2'b00, 32'h0,        4'b0100, 2, 32'h11220000};
    vecs[9]  = '{1'b0, 32'h8,  32'h0,        4'h0,    2'b00, 32'h11220000, 4'b0000, 2, 32'h11220000};
    vecs[10] = '{1'b0, 32'h1,  32'h0,        4'h0,    2'b00, 32'h00000000, 4'b0000, 0, 32'h00000000};
    vecs[11] = '{1'b1, 32'h7,  32'h0000FF00, 4'b0010, 2'b00, 32'h0,        4'b0010, 1, 32'hDEADFFAA};

    req        = '0;
    rd_only    = '0;
    rd_only[3] = 32'h12345678;
    rst_ni     = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_aw_ready", resp.aw_ready, 1'b0);
    check("rst_w_ready", resp.w_ready, 1'b0);
    check("rst_b_valid", resp.b_valid, 1'b0);
    check("rst_r_valid", resp.r_valid, 1'b0);
    check("rst_ar_ready", resp.ar_ready, 1'b1);
    check("rst_b_resp", resp.b.resp, 2'b00);
    check("rst_r_resp", resp.r.resp, 2'b00);
    check("rst_r_data", resp.r.data, 32'h0);
    check("rst_regs_lo", reg_q[2:0], 96'h0);
    check("rst_reg3_ro", reg_q[3], 32'h12345678);
    check("rst_pulse", wr_pulse, 4'b0000);

    // Lone AW must not be accepted.
    @(negedge clk_i);
    req.aw.addr  = 32'h0;
    req.aw_valid = 1'b1;
    req.b_ready  = 1'b1;
    #1;
    check("lone_aw_ready", resp.aw_ready, 1'b0);
    req.aw_valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else do_read(vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_rdata);
    end

    // B stall: first write held in RESP while a second AW+W waits.
    @(negedge clk_i);
    req.aw.addr  = 32'h0;
    req.w.data   = 32'h00000001;
    req.w.strb   = 4'hF;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    req.b_ready  = 1'b0;
    @(negedge clk_i);
    req.aw.addr = 32'h10;
    req.w.data  = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_b_valid", resp.b_valid, 1'b1);
      check("stall_b_resp", resp.b.resp, 2'b00);
      check("stall_aw_w_ready", {resp.aw_ready, resp.w_ready}, 2'b00);
      @(negedge clk_i);
    end
    req.b_ready = 1'b1;
    #1;
    check("release_ready", {resp.aw_ready, resp.w_ready}, 2'b11);
    @(negedge clk_i);
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    #1;
    check("second_b_valid", resp.b_valid, 1'b1);
    check("second_b_resp", resp.b.resp, 2'b11);
    check("stall_reg0", reg_q[0], 32'h00000001);
    check("stall_reg1", reg_q[1], 32'hDEADFFAA);

    // Same-cycle read and write of register 0: read sees the old value.
    @(negedge clk_i);
    req.ar.addr  = 32'h0;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    req.aw.addr  = 32'h0;
    req.w.data   = 32'h00000055;
    req.w.strb   = 4'hF;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    #1;
    check("same_cyc_ready", {resp.aw_ready, resp.ar_ready}, 2'b11);
    @(negedge clk_i);
    req.ar_valid = 1'b0;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    #1;
    check("same_cyc_r_data", resp.r.data, 32'h00000001);
    check("same_cyc_b_resp", {resp.b_valid, resp.b.resp}, 3'b100);
    do_read(32'h0, 2'b00, 32'h00000055);

    // Reset with R pending.
    @(negedge clk_i);
    req.ar.addr  = 32'h4;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b0;
    @(negedge clk_i);
    req.ar_valid = 1'b0;
    #1;
    check("pre_rst_r_valid", resp.r_valid, 1'b1);
    check("pre_rst_ar_ready", resp.ar_ready, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_r_valid", resp.r_valid, 1'b0);
    check("mid_rst_ar_ready", resp.ar_ready, 1'b1);
    check("mid_rst_r_data", resp.r.data, 32'h0);
    check("mid_rst_reg0", reg_q[0], 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_read(32'h4, 2'b00, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
